// File: rtl/lcd_time_formatter.sv
// lcd_time_formatter
// Converts binary date, time and alarm fields to BCD with a sequential
// double-dabble engine. Results go into a shadow bank. The bank is copied to
// a display bank in one cycle, so the display never shows a partly updated time.
// For the requested cell index, one ASCII character is returned per clock.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   tick_1hz, refresh   one-cycle conversion requests (tick also toggles blink)
//   mode                0 clock, 1 alarm, 2 set, 3 same as clock
//   edit_field          field blanked while blinking in set mode (6/7 none)
//   year..second        binary time fields
//   al_hour..al_sec     binary alarm time
//   alarm_en/ring       alarm armed / alarm currently firing
//   index               requested cell (line 1 starts at COLS)
//   out                 character for index sampled on the previous edge
//   busy, done          conversion in progress / display bank updated pulse
module lcd_time_formatter #(
  parameter int COLS = 16,
  parameter int IDXW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_1hz,
  input  logic            refresh,
  input  logic [1:0]      mode,
  input  logic [2:0]      edit_field,
  input  logic [7:0]      year,
  input  logic [7:0]      month,
  input  logic [7:0]      day,
  input  logic [7:0]      hour,
  input  logic [7:0]      minute,
  input  logic [7:0]      second,
  input  logic [7:0]      al_hour,
  input  logic [7:0]      al_min,
  input  logic [7:0]      al_sec,
  input  logic            alarm_en,
  input  logic            alarm_ring,
  input  logic [IDXW-1:0] index,
  output logic [7:0]      out,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  // Fixed text for each 16-character line. Digit cells are filled in later.
  localparam logic [127:0] T_DATE  = "DATE 2   /  /   ";
  localparam logic [127:0] T_TIME  = "TIME   :  :     ";
  localparam logic [127:0] T_ALRM  = "ALRM   :  :     ";
  localparam logic [127:0] T_AL_ON = "ALARM ON        ";
  localparam logic [127:0] T_AL_OF = "ALARM OFF       ";

  localparam logic [IDXW:0] LINE_W = (IDXW+1)'(COLS);
  localparam logic [IDXW:0] END_W  = (IDXW+1)'(2 * COLS);
  localparam logic [IDXW:0] C16    = (IDXW+1)'(16);

  state_t      state;
  logic [3:0]  field;
  logic [2:0]  bit_cnt;
  logic [19:0] dd;
  logic [19:0] dd_next;
  logic [7:0]  field_val;
  logic [11:0] shadow [9];
  logic [11:0] disp   [9];
  logic        pending;
  logic        boot;
  logic        blink;

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [7:0] pick(input logic [127:0] s, input logic [3:0] c);
    return s[8*(15-int'(c)) +: 8];
  endfunction

  function automatic logic [7:0] dig(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  assign dd_next = dd_step(dd);

  // Field order: year, month, day, hour, minute, second, then the alarm fields.
  always_comb begin
    field_val = 8'd0;
    case (field)
      4'd0:    field_val = year;
      4'd1:    field_val = month;
      4'd2:    field_val = day;
      4'd3:    field_val = hour;
      4'd4:    field_val = minute;
      4'd5:    field_val = second;
      4'd6:    field_val = al_hour;
      4'd7:    field_val = al_min;
      4'd8:    field_val = al_sec;
      default: field_val = 8'd0;
    endcase
  end

  // Conversion FSM. The boot flag forces one conversion after reset release.
  // Requests that arrive while a conversion runs merge into one pending start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      field   <= 4'd0;
      bit_cnt <= 3'd0;
      dd      <= 20'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pending <= 1'b0;
      boot    <= 1'b1;
      blink   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        shadow[i] <= 12'd0;
        disp[i]   <= 12'd0;
      end
    end else begin
      done <= 1'b0;
      if (tick_1hz) blink <= ~blink;
      if ((tick_1hz || refresh) && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (boot || pending || tick_1hz || refresh) begin
            boot    <= 1'b0;
            pending <= 1'b0;
            field   <= 4'd0;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          dd      <= {12'd0, field_val};
          bit_cnt <= 3'd0;
          state   <= SHIFT;
        end
        SHIFT: begin
          dd      <= dd_next;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            shadow[field] <= dd_next[19:8];
            if (field == 4'd8) begin
              state <= COMMIT;
            end else begin
              field <= field + 4'd1;
              state <= LOAD;
            end
          end
        end
        COMMIT: begin
          disp  <= shadow;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [IDXW:0] idx_ext;
  logic [IDXW:0] col;
  logic [3:0]    c;
  logic [3:0]    cell_field;
  logic [3:0]    base;
  logic [1:0]    pos;
  logic [11:0]   bcd;
  logic          line1;
  logic          in_line;
  logic          alarm_view;
  logic [7:0]    ch;

  assign idx_ext    = {1'b0, index};
  assign alarm_view = (mode == 2'd1);

  // Character lookup. A digit cell is tagged with its field (cell_field) and
  // its digit position (pos: 2 hundreds, 1 tens, 0 ones). The digit is filled
  // in from the display bank. Ring blanking of line 1 is applied last, so it
  // overrides every other rule.
  always_comb begin
    ch         = 8'h20;
    col        = '0;
    c          = 4'd0;
    cell_field = 4'hF;
    base       = 4'd3;
    pos        = 2'd0;
    bcd        = 12'd0;
    line1      = 1'b0;
    in_line    = 1'b0;
    if (idx_ext < LINE_W) begin
      in_line = 1'b1;
      col     = idx_ext;
    end else if (idx_ext < END_W) begin
      in_line = 1'b1;
      line1   = 1'b1;
      col     = idx_ext - LINE_W;
    end
    if (in_line && col < C16) begin
      c = col[3:0];
      if (!line1) begin
        if (alarm_view) begin
          ch = alarm_en ? pick(T_AL_ON, c) : pick(T_AL_OF, c);
        end else begin
          ch = pick(T_DATE, c);
          case (c)
            4'd6:  begin cell_field = 4'd0; pos = 2'd2; end
            4'd7:  begin cell_field = 4'd0; pos = 2'd1; end
            4'd8:  begin cell_field = 4'd0; pos = 2'd0; end
            4'd10: begin cell_field = 4'd1; pos = 2'd1; end
            4'd11: begin cell_field = 4'd1; pos = 2'd0; end
            4'd13: begin cell_field = 4'd2; pos = 2'd1; end
            4'd14: begin cell_field = 4'd2; pos = 2'd0; end
            default: ;
          endcase
        end
      end else begin
        ch   = alarm_view ? pick(T_ALRM, c) : pick(T_TIME, c);
        base = alarm_view ? 4'd6 : 4'd3;
        if (!alarm_view && c == 4'd15 && alarm_en) ch = 8'h41;
        case (c)
          4'd5:  begin cell_field = base;        pos = 2'd1; end
          4'd6:  begin cell_field = base;        pos = 2'd0; end
          4'd8:  begin cell_field = base + 4'd1; pos = 2'd1; end
          4'd9:  begin cell_field = base + 4'd1; pos = 2'd0; end
          4'd11: begin cell_field = base + 4'd2; pos = 2'd1; end
          4'd12: begin cell_field = base + 4'd2; pos = 2'd0; end
          default: ;
        endcase
      end
      if (cell_field != 4'hF) begin
        bcd = disp[cell_field];
        if (cell_field == 4'd0) begin
          ch = (pos == 2'd2) ? dig(bcd[11:8]) : (pos == 2'd1) ? dig(bcd[7:4]) : dig(bcd[3:0]);
        end else if (bcd[11:8] != 4'd0) begin
          ch = 8'h2D;
        end else begin
          ch = (pos == 2'd1) ? dig(bcd[7:4]) : dig(bcd[3:0]);
        end
        if (mode == 2'd2 && blink && cell_field < 4'd6 && edit_field == cell_field[2:0]) ch = 8'h20;
      end
    end
    if (line1 && alarm_ring && blink) ch = 8'h20;
  end

  // Lookup result register: out holds the character for the previous index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out <= 8'h00;
    else      out <= ch;
  end

endmodule

// File: tb/tb_lcd_time_formatter.sv
// tb_lcd_time_formatter
// Table-driven bench for lcd_time_formatter. It uses a COLS=16 instance and a
// COLS=20 instance that share all inputs. Multi-cycle behaviour has its own
// hand-written sequences: conversion latency, request merging, blinking, ring
// override, out-of-range rendering and reset abort.
module tb_lcd_time_formatter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       refresh = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] edit_field = 3'd7;
  logic [7:0] year = 8'd24, month = 8'd3, day = 8'd7;
  logic [7:0] hour = 8'd13, minute = 8'd5, second = 8'd9;
  logic [7:0] al_hour = 8'd6, al_min = 8'd30, al_sec = 8'd0;
  logic       alarm_en = 1'b0;
  logic       alarm_ring = 1'b0;
  logic [5:0] index = 6'd0;
  logic [5:0] index20 = 6'd0;
  logic [7:0] out, out20;
  logic       busy, busy20, done, done20;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] vmode;
    logic       aen;
    logic [5:0] idx;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  lcd_time_formatter #(.COLS(16), .IDXW(6)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .refresh(refresh),
    .mode(mode), .edit_field(edit_field),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .second(second),
    .al_hour(al_hour), .al_min(al_min), .al_sec(al_sec),
    .alarm_en(alarm_en), .alarm_ring(alarm_ring), .index(index),
    .out(out), .busy(busy), .done(done)
  );

  lcd_time_formatter #(.COLS(20), .IDXW(6)) dut20 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .refresh(refresh),
    .mode(mode), .edit_field(edit_field),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .second(second),
    .al_hour(al_hour), .al_min(al_min), .al_sec(al_sec),
    .alarm_en(alarm_en), .alarm_ring(alarm_ring), .index(index20),
    .out(out20), .busy(busy20), .done(done20)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Present an index to both instances, then wait one edge so out reflects it.
  task automatic applyStimulus(input logic [5:0] idx);
    index   = idx;
    index20 = idx;
    @(negedge clk);
  endtask

  task automatic pulseTick();
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  // Wait until busy has been low for three samples, so a pending restart is not missed.
  task automatic waitIdle();
    int quiet = 0;
    for (int k = 0; k < 1000 && quiet < 3; k++) begin
      @(negedge clk);
      if (!busy) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      failures++;
      $display("[TB] FAIL waitIdle busy=%0b required=0 within bound", busy);
    end
  endtask

  initial begin
    string l0   = "DATE 2024/03/07 ";
    string l1   = "TIME 13:05:09   ";
    string a0of = "ALARM OFF       ";
    string a0on = "ALARM ON        ";
    string a1   = "ALRM 06:30:00   ";
    int first_done;
    int second_done;
    int pulses;
    int pulses20;
    int first20;

    for (int i = 0; i < 16; i++) begin
      vecs.push_back('{2'd0, 1'b0, 6'(i),      8'(l0[i])});
      vecs.push_back('{2'd0, 1'b0, 6'(16 + i), 8'(l1[i])});
      vecs.push_back('{2'd1, 1'b0, 6'(i),      8'(a0of[i])});
      vecs.push_back('{2'd1, 1'b0, 6'(16 + i), 8'(a1[i])});
      vecs.push_back('{2'd1, 1'b1, 6'(i),      8'(a0on[i])});
    end
    vecs.push_back('{2'd0, 1'b1, 6'd31, 8'h41});
    vecs.push_back('{2'd1, 1'b1, 6'd31, 8'h20});
    vecs.push_back('{2'd3, 1'b0, 6'd0,  8'h44});
    vecs.push_back('{2'd3, 1'b1, 6'd31, 8'h41});
    vecs.push_back('{2'd0, 1'b0, 6'd32, 8'h20});
    vecs.push_back('{2'd0, 1'b0, 6'd63, 8'h20});
    vecs.push_back('{2'd2, 1'b0, 6'd8,  8'h34});

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_out", out, 8'h00);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);

    // Automatic first conversion: done pulses 82 cycles after the start edge
    rst = 1'b1;
    first_done = -1; pulses = 0; pulses20 = 0; first20 = -1;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      if (cyc == 1) checkOutput("boot_busy", busy, 1'b1);
      if (done) begin pulses++; if (first_done < 0) first_done = cyc; end
      if (done20) begin pulses20++; if (first20 < 0) first20 = cyc; end
    end
    checkOutput("boot_done_cycle", first_done, 83);
    checkOutput("boot_done_pulses", pulses, 1);
    checkOutput("boot_done20_cycle", first20, 83);
    checkOutput("boot_done20_pulses", pulses20, 1);
    checkOutput("boot_idle_busy20", busy20, 1'b0);

    // Table vectors
    foreach (vecs[v]) begin
      mode     = vecs[v].vmode;
      alarm_en = vecs[v].aen;
      applyStimulus(vecs[v].idx);
      checkOutput($sformatf("vec%0d_mode%0d_idx%0d", v, vecs[v].vmode, vecs[v].idx), out, vecs[v].exp);
    end
    mode = 2'd0; alarm_en = 1'b0;

    // COLS=20 geometry
    applyStimulus(6'd0);  checkOutput("c20_idx0", out20, 8'h44);
    applyStimulus(6'd15); checkOutput("c20_idx15", out20, 8'h20);
    applyStimulus(6'd16); checkOutput("c20_idx16", out20, 8'h20);
    applyStimulus(6'd17); checkOutput("c20_idx17", out20, 8'h20);
    applyStimulus(6'd20); checkOutput("c20_idx20", out20, 8'h54);
    applyStimulus(6'd25); checkOutput("c20_idx25", out20, 8'h31);
    applyStimulus(6'd26); checkOutput("c20_idx26", out20, 8'h33);
    applyStimulus(6'd36); checkOutput("c20_idx36", out20, 8'h20);
    applyStimulus(6'd40); checkOutput("c20_idx40", out20, 8'h20);

    // Set-mode blinking of the minute field
    mode = 2'd2; edit_field = 3'd4;
    pulseTick();
    applyStimulus(6'd24); checkOutput("blink1_idx24", out, 8'h20);
    applyStimulus(6'd25); checkOutput("blink1_idx25", out, 8'h20);
    applyStimulus(6'd23); checkOutput("blink1_idx23", out, 8'h3A);
    applyStimulus(6'd8);  checkOutput("blink1_idx8", out, 8'h34);
    pulseTick();
    applyStimulus(6'd24); checkOutput("blink0_idx24", out, 8'h30);
    applyStimulus(6'd25); checkOutput("blink0_idx25", out, 8'h35);
    applyStimulus(6'd23); checkOutput("blink0_idx23", out, 8'h3A);
    edit_field = 3'd0;
    pulseTick();
    applyStimulus(6'd8);  checkOutput("blink_year_idx8", out, 8'h20);
    applyStimulus(6'd9);  checkOutput("blink_year_idx9", out, 8'h2F);
    applyStimulus(6'd24); checkOutput("blink_year_idx24", out, 8'h30);
    edit_field = 3'd7;
    applyStimulus(6'd8);  checkOutput("blink_none_idx8", out, 8'h34);

    // Ring override while blink=1
    mode = 2'd0; alarm_en = 1'b1; alarm_ring = 1'b1;
    for (int i = 16; i < 32; i++) begin
      applyStimulus(6'(i));
      checkOutput($sformatf("ring_idx%0d", i), out, 8'h20);
    end
    applyStimulus(6'd0);  checkOutput("ring_line0_idx0", out, 8'h44);
    mode = 2'd1;
    applyStimulus(6'd21); checkOutput("ring_mode1_idx21", out, 8'h20);
    mode = 2'd0;
    pulseTick();
    applyStimulus(6'd31); checkOutput("ring_blink0_idx31", out, 8'h41);
    applyStimulus(6'd16); checkOutput("ring_blink0_idx16", out, 8'h54);
    alarm_ring = 1'b0; alarm_en = 1'b0;
    waitIdle();

    // Refresh plus a merged second request while busy
    minute = 8'd120; year = 8'd255;
    refresh = 1'b1;
    @(negedge clk);
    first_done = -1; second_done = -1; pulses = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      refresh = (cyc == 10);
      @(negedge clk);
      if (done) begin
        pulses++;
        if (first_done < 0) first_done = cyc;
        else if (second_done < 0) second_done = cyc;
      end
    end
    refresh = 1'b0;
    checkOutput("refresh_first_done", first_done, 82);
    checkOutput("refresh_gap", second_done - first_done, 83);
    checkOutput("refresh_pulses", pulses, 2);

    // Out-of-range rendering
    applyStimulus(6'd24); checkOutput("oor_idx24", out, 8'h2D);
    applyStimulus(6'd25); checkOutput("oor_idx25", out, 8'h2D);
    applyStimulus(6'd23); checkOutput("oor_idx23", out, 8'h3A);
    applyStimulus(6'd5);  checkOutput("oor_idx5", out, 8'h32);
    applyStimulus(6'd6);  checkOutput("oor_idx6", out, 8'h32);
    applyStimulus(6'd7);  checkOutput("oor_idx7", out, 8'h35);
    applyStimulus(6'd8);  checkOutput("oor_idx8", out, 8'h35);

    // Reset 40 cycles into a conversion
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    repeat (39) @(negedge clk);
    checkOutput("abort_busy_before", busy, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_out", out, 8'h00);
    repeat (2) @(negedge clk);
    index = 6'd7;
    rst = 1'b1;
    first_done = -1; pulses = 0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      if (cyc == 1) checkOutput("abort_bank_zero", out, 8'h30);
      if (cyc == 1) checkOutput("abort_restart_busy", busy, 1'b1);
      if (cyc == 84) checkOutput("abort_new_bank", out, 8'h35);
      if (done) begin pulses++; if (first_done < 0) first_done = cyc; end
    end
    checkOutput("abort_done_cycle", first_done, 83);
    checkOutput("abort_done_pulses", pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
